vga_timing: RTL and testbench



---
 rtl/vga_pkg.sv | 25 ++
 rtl/phase_counter.sv | 57 +++++
 rtl/vga_timing.sv | 107 ++++++++++
 tb/tb_vga_timing.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the raster phase type.
// Defaults describe 640x480 at 60 Hz from a 100 MHz system clock.
package vga_pkg;

   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FP     = 2'd1,
      SYNC   = 2'd2,
      BP     = 2'd3
   } phase_t;

endpackage

// File: rtl/phase_counter.sv
// One raster axis: a wrapping count plus an ACTIVE/FP/SYNC/BP phase FSM
// that steps in lockstep with the count, so phase always matches the count range.
module phase_counter
   import vga_pkg::*;
#(
   parameter int W          = 10,
   parameter int ACTIVE_LEN = DEF_H_ACTIVE,
   parameter int FP_LEN     = DEF_H_FP,
   parameter int SYNC_LEN   = DEF_H_SYNC,
   parameter int BP_LEN     = DEF_H_BP
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output phase_t       phase,
   output logic         wrap
);

   localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

   localparam logic [W-1:0] LAST_ACTIVE = W'(ACTIVE_LEN - 1);
   localparam logic [W-1:0] LAST_FP     = W'(ACTIVE_LEN + FP_LEN - 1);
   localparam logic [W-1:0] LAST_SYNC   = W'(ACTIVE_LEN + FP_LEN + SYNC_LEN - 1);
   localparam logic [W-1:0] LAST        = W'(TOTAL - 1);

   phase_t phase_next;

   assign wrap = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= ACTIVE;
      end else begin
         if (en) begin
            cnt <= wrap ? '0 : cnt + W'(1);
         end
         phase <= phase_next;
      end
   end

   // Transitions fire on the last count of each phase, together with the count step.
   always_comb begin
      phase_next = phase;
      if (en) begin
         unique case (phase)
            ACTIVE:  if (cnt == LAST_ACTIVE) phase_next = FP;
            FP:      if (cnt == LAST_FP)     phase_next = SYNC;
            SYNC:    if (cnt == LAST_SYNC)   phase_next = BP;
            BP:      if (cnt == LAST)        phase_next = ACTIVE;
            default: phase_next = ACTIVE;
         endcase
      end
   end

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: pixel-rate divider, horizontal and vertical
// phase counters, and a registered output stage for coordinates, syncs and strobes.
module vga_timing
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] p_col,
   output logic [9:0] p_row,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       pixel_tick,
   output logic       frame_start
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;
   logic             pe;
   logic             pe_q;
   logic             frame_q;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   phase_t           h_phase;
   phase_t           v_phase;
   logic             h_wrap;
   logic             v_wrap;

   assign pe = (div == DIV_LAST);

   // pe_q and frame_q mark "counters just stepped" so the strobes line up with the output stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div     <= '0;
         pe_q    <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         div     <= pe ? '0 : div + DIV_W'(1);
         pe_q    <= pe;
         frame_q <= v_wrap;
      end
   end

   phase_counter #(
      .W          (10),
      .ACTIVE_LEN (H_ACTIVE),
      .FP_LEN     (H_FP),
      .SYNC_LEN   (H_SYNC),
      .BP_LEN     (H_BP)
   ) u_h (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pe),
      .cnt   (h_cnt),
      .phase (h_phase),
      .wrap  (h_wrap)
   );

   phase_counter #(
      .W          (10),
      .ACTIVE_LEN (V_ACTIVE),
      .FP_LEN     (V_FP),
      .SYNC_LEN   (V_SYNC),
      .BP_LEN     (V_BP)
   ) u_v (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (h_wrap),
      .cnt   (v_cnt),
      .phase (v_phase),
      .wrap  (v_wrap)
   );

   // Output stage is reset too, so a mid-frame reset drops any sync pulse on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_col       <= '0;
         p_row       <= '0;
         video_on    <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         pixel_tick  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         p_col       <= h_cnt;
         p_row       <= v_cnt;
         video_on    <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
         hsync       <= (h_phase != SYNC);
         vsync       <= (v_phase != SYNC);
         pixel_tick  <= pe_q;
         frame_start <= frame_q;
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: an arithmetic raster model predicts every output
// cycle for a default instance and two reduced-geometry instances.
module tb_vga_timing;

   typedef struct packed {
      logic [9:0] col;
      logic [9:0] row;
      logic       von;
      logic       hs;
      logic       vs;
      logic       tick;
      logic       fs;
   } outs_t;

   typedef struct {
      int div;
      int ha;
      int hf;
      int hsw;
      int hb;
      int va;
      int vf;
      int vsw;
      int vb;
   } cfg_t;

   logic clk = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   logic rst_c = 1'b0;

   logic [9:0] col_a, row_a, col_b, row_b, col_c, row_c;
   logic von_a, hs_a, vs_a, tick_a, fs_a;
   logic von_b, hs_b, vs_b, tick_b, fs_b;
   logic von_c, hs_c, vs_c, tick_c, fs_c;

   int    sel;
   int    n;
   int    errors;
   int    checks;
   cfg_t  cfg;
   outs_t obs;
   outs_t prev;
   outs_t exp_q[$];

   int first_tick, hs_fall, hs_rise, hs_low, von_fall, wrap_row, wrap_seen;
   int tick_low, tick_cnt, fs_count, last_fs, fs_period;
   int hs_min, hs_max, vs_min, vs_max, found;

   always #5 clk = ~clk;

   vga_timing dut_a (
      .clk (clk), .rst_n (rst_a),
      .p_col (col_a), .p_row (row_a), .video_on (von_a),
      .hsync (hs_a), .vsync (vs_a), .pixel_tick (tick_a), .frame_start (fs_a)
   );

   vga_timing #(
      .CLK_DIV (1), .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
   ) dut_b (
      .clk (clk), .rst_n (rst_b),
      .p_col (col_b), .p_row (row_b), .video_on (von_b),
      .hsync (hs_b), .vsync (vs_b), .pixel_tick (tick_b), .frame_start (fs_b)
   );

   vga_timing #(
      .CLK_DIV (3), .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1)
   ) dut_c (
      .clk (clk), .rst_n (rst_c),
      .p_col (col_c), .p_row (row_c), .video_on (von_c),
      .hsync (hs_c), .vsync (vs_c), .pixel_tick (tick_c), .frame_start (fs_c)
   );

   // Only the selected instance is observed at any time.
   always_comb begin
      obs = '0;
      case (sel)
         0:       obs = {col_a, row_a, von_a, hs_a, vs_a, tick_a, fs_a};
         1:       obs = {col_b, row_b, von_b, hs_b, vs_b, tick_b, fs_b};
         default: obs = {col_c, row_c, von_c, hs_c, vs_c, tick_c, fs_c};
      endcase
   end

   // Output expected after the edge that ends cycle n (n < 0 means that edge saw reset).
   function automatic outs_t model(input int cyc, input cfg_t c);
      outs_t o;
      int ht, vt, p, col, row;
      o    = '0;
      o.hs = 1'b1;
      o.vs = 1'b1;
      if (cyc < 0) return o;
      ht  = c.ha + c.hf + c.hsw + c.hb;
      vt  = c.va + c.vf + c.vsw + c.vb;
      p   = cyc / c.div;
      col = p % ht;
      row = (p / ht) % vt;
      o.col  = 10'(col);
      o.row  = 10'(row);
      o.von  = (col < c.ha) && (row < c.va);
      o.hs   = !((col >= c.ha + c.hf) && (col < c.ha + c.hf + c.hsw));
      o.vs   = !((row >= c.va + c.vf) && (row < c.va + c.vf + c.vsw));
      o.tick = (cyc > 0) && (cyc % c.div == 0);
      o.fs   = o.tick && (col == 0) && (row == 0);
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("[TB] FAIL %s: got %0d, expected %0d (dut %0d, cycle %0d)", tag, got, want, sel, n);
      end
   endtask

   task automatic checkOutput();
      outs_t e;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
         return;
      end
      e = exp_q.pop_front();
      check("p_col",       obs.col,  e.col);
      check("p_row",       obs.row,  e.row);
      check("video_on",    obs.von,  e.von);
      check("hsync",       obs.hs,   e.hs);
      check("vsync",       obs.vs,   e.vs);
      check("pixel_tick",  obs.tick, e.tick);
      check("frame_start", obs.fs,   e.fs);
   endtask

   task automatic applyStimulus(input logic rst_val);
      case (sel)
         0:       rst_a = rst_val;
         1:       rst_b = rst_val;
         default: rst_c = rst_val;
      endcase
      n = rst_val ? n + 1 : -1;
      exp_q.push_back(model(n, cfg));
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      n      = -1;

      // Default geometry: reset values, first pixel tick, hsync window, line wrap.
      sel = 0;
      cfg = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
      $display("[TB] default 640x480 instance");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0);
      first_tick = -1; hs_fall = -1; hs_rise = -1; hs_low = 0;
      von_fall = -1; wrap_row = -1; wrap_seen = 0;
      for (int i = 0; i < 6410; i++) begin
         prev = obs;
         applyStimulus(1'b1);
         if (obs.tick && first_tick < 0) first_tick = n;
         if (prev.hs && !obs.hs && hs_fall < 0) hs_fall = int'(obs.col);
         if (!prev.hs && obs.hs && hs_rise < 0) hs_rise = int'(obs.col);
         if (!obs.hs && obs.row == 10'd0) hs_low++;
         if (prev.von && !obs.von && von_fall < 0) von_fall = int'(obs.col);
         if (prev.col == 10'd799 && obs.col == 10'd0 && wrap_seen == 0) begin
            wrap_seen = 1;
            wrap_row  = int'(obs.row);
         end
      end
      check("first_pixel_tick_cycle", first_tick, 4);
      check("hsync_fall_col", hs_fall, 656);
      check("hsync_rise_col", hs_rise, 752);
      check("hsync_low_clks", hs_low, 384);
      check("video_on_fall_col", von_fall, 640);
      check("line_wrap_row", wrap_row, 1);

      // Reduced geometry, CLK_DIV=1: 84-clk frames, sync windows, mid-frame reset.
      sel = 1;
      n   = -1;
      cfg = '{1, 8, 1, 2, 1, 4, 1, 1, 1};
      $display("[TB] reduced geometry, CLK_DIV=1");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0);
      tick_low = 0; fs_count = 0; last_fs = -1; fs_period = -1;
      hs_min = 1023; hs_max = -1; vs_min = 1023; vs_max = -1;
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1);
         if (n >= 1 && !obs.tick) tick_low++;
         if (obs.fs) begin
            if (last_fs >= 0 && fs_period < 0) fs_period = n - last_fs;
            last_fs = n;
            fs_count++;
         end
         if (!obs.hs) begin
            if (int'(obs.col) < hs_min) hs_min = int'(obs.col);
            if (int'(obs.col) > hs_max) hs_max = int'(obs.col);
         end
         if (!obs.vs) begin
            if (int'(obs.row) < vs_min) vs_min = int'(obs.row);
            if (int'(obs.row) > vs_max) vs_max = int'(obs.row);
         end
      end
      check("tick_low_after_reset", tick_low, 0);
      check("frame_start_count", fs_count, 3);
      check("frame_period_clks", fs_period, 84);
      check("hsync_low_min_col", hs_min, 9);
      check("hsync_low_max_col", hs_max, 10);
      check("vsync_low_min_row", vs_min, 5);
      check("vsync_low_max_row", vs_max, 5);

      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         applyStimulus(1'b1);
         if (obs.row == 10'd5) found = 1;
      end
      check("reached_vsync_row", found, 1);
      check("vsync_low_before_reset", obs.vs, 1'b0);
      applyStimulus(1'b0);
      check("reset_vsync", obs.vs, 1'b1);
      check("reset_hsync", obs.hs, 1'b1);
      check("reset_col", obs.col, 10'd0);
      check("reset_row", obs.row, 10'd0);
      check("reset_video_on", obs.von, 1'b0);
      for (int i = 0; i < 100; i++) applyStimulus(1'b1);

      // Reduced geometry, CLK_DIV=3: frame period scales with the divider.
      sel = 2;
      n   = -1;
      cfg = '{3, 8, 1, 2, 1, 4, 1, 1, 1};
      $display("[TB] reduced geometry, CLK_DIV=3");
      for (int i = 0; i < 2; i++) applyStimulus(1'b0);
      tick_cnt = 0; last_fs = -1; fs_period = -1;
      for (int i = 0; i < 514; i++) begin
         applyStimulus(1'b1);
         if (obs.tick) tick_cnt++;
         if (obs.fs) begin
            if (last_fs >= 0 && fs_period < 0) fs_period = n - last_fs;
            last_fs = n;
         end
      end
      check("div3_tick_count", tick_cnt, 171);
      check("div3_frame_period_clks", fs_period, 252);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
